// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types for the hazard/flush controller: register index width and
// the memory-wait FSM state encoding.
package hazard_flush_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline stall/flush controller: load-use, taken-branch and memory-wait
// handling, with saturating event counters and a sticky memory-timeout flag.
module hazard_flush_ctrl
    import hazard_flush_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] RP1_OF,
    input  logic [REG_IDX_W-1:0] RP2_OF,
    input  logic                 useRP1_OF,
    input  logic                 useRP2_OF,
    input  logic [REG_IDX_W-1:0] rd_ALU,
    input  logic                 is_Ld_ALU,
    input  logic                 isWb_ALU,
    input  logic                 isBranchTaken_ALU,
    input  logic                 memBusy_MA,
    output logic                 pcSel,
    output logic                 stall_PC,
    output logic                 stall_IFOF,
    output logic                 flush_IFOF,
    output logic                 stall_OFALU,
    output logic                 flush_OFALU,
    output logic                 stall_ALUMA,
    output logic [CNT_W-1:0]     stallCount,
    output logic [CNT_W-1:0]     flushCount,
    output logic                 memTimeout
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

    logic load_use;
    logic stall_inc;
    logic flush_inc;

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q;

    // r0 is compared like any other index; the OF decoder already masks unused ports.
    assign load_use = is_Ld_ALU && isWb_ALU &&
                      ((useRP1_OF && (RP1_OF == rd_ALU)) ||
                       (useRP2_OF && (RP2_OF == rd_ALU)));

    always_comb begin
        pcSel       = 1'b0;
        stall_PC    = 1'b0;
        stall_IFOF  = 1'b0;
        flush_IFOF  = 1'b0;
        stall_OFALU = 1'b0;
        flush_OFALU = 1'b0;
        stall_ALUMA = 1'b0;
        if (reset) begin
            flush_IFOF  = 1'b1;
            flush_OFALU = 1'b1;
        end else if (memBusy_MA) begin
            // Freezing ALU/MA also freezes any taken branch until memory releases.
            stall_PC    = 1'b1;
            stall_IFOF  = 1'b1;
            stall_OFALU = 1'b1;
            stall_ALUMA = 1'b1;
        end else if (isBranchTaken_ALU) begin
            pcSel       = 1'b1;
            flush_IFOF  = 1'b1;
            flush_OFALU = 1'b1;
        end else if (load_use) begin
            stall_PC    = 1'b1;
            stall_IFOF  = 1'b1;
            flush_OFALU = 1'b1;
        end
    end

    assign stall_inc = !reset && (memBusy_MA || (!isBranchTaken_ALU && load_use));
    assign flush_inc = !reset && !memBusy_MA && isBranchTaken_ALU;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (memBusy_MA) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (memBusy_MA) begin
                    if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d == WAIT_MAX) timeout_q <= 1'b1;
        end
    end

    assign memTimeout = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flushCount)
    );

endmodule
